// File: rtl/uart_pkg.sv
// Shared constants and helpers for the parametrised UART receiver.
// Holds the parity mode codes, the receive FSM state encoding, the frame
// length calculation and the 3-sample majority vote.
package uart_pkg;

  // Parity modes
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Receive FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Total bits on the line for one frame: start + data + optional parity + stop
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 32'sd1 + data_bits + ((parity != 32'sd0) ? 32'sd1 : 32'sd0) + stop_bits;
  endfunction

  // Majority of three samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: 2-flop synchroniser, falling-edge detect,
// per-bit timing counter and 3-sample majority vote around mid-bit.
// bit_strobe/bit_val are valid in the cycle the counter sits at MID+1.
module uart_rx_sampler #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  input  logic run,
  output logic rx_s,
  output logic fall_edge,
  output logic bit_strobe,
  output logic bit_val
);
  import uart_pkg::*;

  localparam int             CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  SMP_A    = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  SMP_B    = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0]  SMP_C    = CW'(BAUD_DIV / 2 + 1);

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_prev_r;
  logic [CW-1:0] cnt_r;
  logic          smp_a_r;
  logic          smp_b_r;

  assign rx_s       = rx_sync_r;
  assign fall_edge  = rx_prev_r & ~rx_sync_r;
  assign bit_strobe = run & (cnt_r == SMP_C);
  assign bit_val    = maj3(smp_a_r, smp_b_r, rx_sync_r);

  // Synchronise the asynchronous line and keep last value for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Bit timing counter: held at 0 while idle, wraps every BAUD_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_a_r <= 1'b1;
      smp_b_r <= 1'b1;
    end else begin
      if (run && (cnt_r == SMP_A)) smp_a_r <= rx_sync_r;
      if (run && (cnt_r == SMP_B)) smp_b_r <= rx_sync_r;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-vote sampling, per-word framing/parity flags, sticky overrun and a
// valid/ready output handshake.
// Optional feature macro: UART_RX_BREAK_DET_EN adds o_break line-break detect.
module uart_rx_param #(
  parameter int BAUD_DIV  = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 o_break,
`endif
  output logic                 o_busy
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY != int'(PAR_NONE));
  localparam logic       ODD_SEL   = (PARITY == int'(PAR_ODD));

  logic                 rx_s;
  logic                 fall_edge;
  logic                 bit_strobe;
  logic                 bit_val;
  logic                 run_s;
  logic                 par_exp_s;
  logic                 hs_s;
  logic                 brk_hold_s;

  logic [2:0]           state_r,  state_nx;
  logic [3:0]           idx_r,    idx_nx;
  logic [DATA_BITS-1:0] shift_r,  shift_nx;
  logic                 perr_r,   perr_nx;
  logic                 ferr_r,   ferr_nx;
  logic                 commit_s;

  assign run_s     = (state_r != IDLE);
  assign par_exp_s = (^shift_r) ^ ODD_SEL;
  assign hs_s      = o_valid & i_ready;

  uart_rx_sampler #(
    .BAUD_DIV (BAUD_DIV)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .run        (run_s),
    .rx_s       (rx_s),
    .fall_edge  (fall_edge),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  // Frame sequencing: next state, bit index, shift register and error flags
  always_comb begin
    state_nx = state_r;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    perr_nx  = perr_r;
    ferr_nx  = ferr_r;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A frame only starts on a genuine 1->0 transition of a low line
        if (fall_edge && !rx_s) begin
          state_nx = START;
          idx_nx   = 4'd0;
          perr_nx  = 1'b0;
          ferr_nx  = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (bit_strobe) begin
          // A start bit that votes high was a glitch; drop it silently
          state_nx = bit_val ? IDLE : DATA;
          idx_nx   = 4'd0;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_nx = {bit_val, shift_r[DATA_BITS-1:1]};
          if (idx_r == LAST_DATA) begin
            state_nx = PAR_EN ? uart_pkg::PARITY : STOP;
            idx_nx   = 4'd0;
          end else begin
            idx_nx = idx_r + 4'd1;
          end
        end else begin
          state_nx = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (bit_strobe) begin
          perr_nx  = (bit_val != par_exp_s);
          state_nx = STOP;
          idx_nx   = 4'd0;
        end else begin
          state_nx = uart_pkg::PARITY;
        end
      end
      STOP: begin
        if (bit_strobe) begin
          if (!bit_val) ferr_nx = 1'b1;
          // Commit on the last stop resolve rather than waiting out the bit
          if (idx_r == LAST_STOP) begin
            commit_s = 1'b1;
            state_nx = IDLE;
          end else begin
            idx_nx = idx_r + 4'd1;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
  end

  // FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      shift_r <= '0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      shift_r <= shift_nx;
      perr_r  <= perr_nx;
      ferr_r  <= ferr_nx;
      o_busy  <= (state_nx != IDLE);
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (hs_s) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end
      if (commit_s && !brk_hold_s) begin
        if (!o_valid || hs_s) begin
          o_data       <= shift_r;
          o_frame_err  <= ferr_nx;
          o_parity_err <= perr_nx;
          o_valid      <= 1'b1;
        end else begin
          // Consumer still holds the previous word: drop this frame
          o_overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  localparam int BRK_LIM = frame_len(DATA_BITS, PARITY, STOP_BITS) * BAUD_DIV;
  localparam int BW      = $clog2(BRK_LIM + 1);

  logic [BW-1:0] brk_cnt_r;

  assign brk_hold_s = o_break;

  // Count consecutive low clocks; flag break once longer than a whole frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_cnt_r <= '0;
      o_break   <= 1'b0;
    end else if (rx_s) begin
      brk_cnt_r <= '0;
      o_break   <= 1'b0;
    end else if (brk_cnt_r == BW'(BRK_LIM)) begin
      o_break   <= 1'b1;
    end else begin
      brk_cnt_r <= brk_cnt_r + BW'(1);
    end
  end
`else
  assign brk_hold_s = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at
// BAUD_DIV = 16, a vector table, hand-written corner sequences and random
// frames checked against a frame-level reference model.
module tb_uart_rx_param;

  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx   [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic       vld  [3];
  logic       fe   [3];
  logic       pe   [3];
  logic       ovr  [3];
  logic       busy [3];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } obs_t;
  obs_t obs_q[$];

  int   cur_wid[3] = '{0, 0, 0};
  int   last_wid[3] = '{0, 0, 0};
  logic vprev[3] = '{1'b0, 1'b0, 1'b0};

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       flip;
    logic [1:0] stops;
    logic [7:0] e_data;
    logic       e_fe;
    logic       e_pe;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .i_rx(rx[0]), .o_data(dout[0]), .o_valid(vld[0]), .i_ready(rdy[0]),
    .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_overrun(ovr[0]), .o_busy(busy[0]));
  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .i_rx(rx[1]), .o_data(dout[1]), .o_valid(vld[1]), .i_ready(rdy[1]),
    .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_overrun(ovr[1]), .o_busy(busy[1]));
  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .i_rx(rx[2]), .o_data(dout[2]), .o_valid(vld[2]), .i_ready(rdy[2]),
    .o_frame_err(fe[2]), .o_parity_err(pe[2]), .o_overrun(ovr[2]), .o_busy(busy[2]));

  // Record every rising o_valid with its word, flags and cycle; track pulse width
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !vprev[i]) obs_q.push_back('{i, dout[i], fe[i], pe[i], cyc});
      if (vld[i]) begin
        cur_wid[i] <= cur_wid[i] + 1;
      end else if (cur_wid[i] != 0) begin
        last_wid[i] <= cur_wid[i];
        cur_wid[i]  <= 0;
      end
      vprev[i] <= vld[i];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Clocks from the falling start edge to o_valid: last stop bit index * B + mid-bit
  // resolve + sync/edge/commit overhead
  function automatic int exp_lat(input int d);
    int last_idx;
    last_idx = 1 + 8 + ((d == 1) ? 1 : 0) + ((d == 2) ? 2 : 1) - 1;
    return 3 + last_idx * B + B / 2 + 2;
  endfunction

  function automatic int count_obs(input int d);
    int n = 0;
    foreach (obs_q[k]) if (obs_q[k].d == d) n++;
    return n;
  endfunction

  // Drive one frame on line d; optionally pulse reset halfway through bit rst_bit
  task automatic send(input int d, input logic [7:0] data, input logic flip,
                      input logic [1:0] stop_val, input logic idle_lvl,
                      input int rst_bit, output int t0);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (d == 1) bits.push_back((($countones(data) % 2) == 1) ^ flip);
    bits.push_back(stop_val[0]);
    if (d == 2) bits.push_back(stop_val[1]);
    repeat (4) @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < bits.size(); i++) begin
      rx[d] = bits[i];
      if (i == rst_bit) begin
        repeat (B / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx[d] = 1'b1;
        return;
      end
      repeat (B) @(negedge clk);
    end
    rx[d] = idle_lvl;
  endtask

  task automatic expect_word(input string name, input int d, input logic [7:0] data,
                             input logic efe, input logic epe, input int t0);
    int found = -1;
    for (int w = 0; w < 4 * B && found < 0; w++) begin
      foreach (obs_q[k]) if (found < 0 && obs_q[k].d == d) found = k;
      if (found < 0) @(negedge clk);
    end
    if (found < 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s: no word delivered, expected data 0x%0h", name, data);
    end else begin
      obs_t o;
      o = obs_q[found];
      obs_q.delete(found);
      chk({name, " data"}, int'(o.data), int'(data));
      chk({name, " frame_err"}, int'(o.fe), int'(efe));
      chk({name, " parity_err"}, int'(o.pe), int'(epe));
      chk({name, " latency"}, o.cyc - t0, exp_lat(d));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int d;
    logic [7:0] data;
    logic flip;
    logic ok;

    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{2, 8'hC3, 1'b0, 2'b11, 8'hC3, 1'b0, 1'b0};
    tbl[4] = '{2, 8'h7E, 1'b0, 2'b10, 8'h7E, 1'b1, 1'b0};
    tbl[5] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{0, 8'hFF, 1'b0, 2'b10, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{1, 8'h01, 1'b0, 2'b10, 8'h01, 1'b1, 1'b0};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset valid[%0d]", i), int'(vld[i]), 0);
      chk($sformatf("reset data[%0d]", i), int'(dout[i]), 0);
      chk($sformatf("reset busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("reset overrun[%0d]", i), int'(ovr[i]), 0);
    end

    // Vector table
    for (int v = 0; v < 8; v++) begin
      send(tbl[v].d, tbl[v].data, tbl[v].flip, tbl[v].stops, 1'b1, -1, t0);
      expect_word($sformatf("vec%0d", v), tbl[v].d, tbl[v].e_data, tbl[v].e_fe, tbl[v].e_pe, t0);
      chk($sformatf("vec%0d valid width", v), last_wid[tbl[v].d], 1);
      chk($sformatf("vec%0d overrun", v), int'(ovr[tbl[v].d]), 0);
    end

    // 8N2 second stop low, then line held low: no new frame until it goes high
    send(2, 8'h5C, 1'b0, 2'b01, 1'b0, -1, t0);
    expect_word("stop2 low", 2, 8'h5C, 1'b1, 1'b0, t0);
    repeat (3 * B) @(negedge clk);
    chk("held low busy", int'(busy[2]), 0);
    chk("held low no word", count_obs(2), 0);
    rx[2] = 1'b1;
    send(2, 8'h81, 1'b0, 2'b11, 1'b1, -1, t0);
    expect_word("after low", 2, 8'h81, 1'b0, 1'b0, t0);

    // Overrun with i_ready low
    rdy[0] = 1'b0;
    send(0, 8'h11, 1'b0, 2'b11, 1'b1, -1, t0);
    expect_word("ovr first", 0, 8'h11, 1'b0, 1'b0, t0);
    send(0, 8'h22, 1'b0, 2'b11, 1'b1, -1, t0);
    repeat (4) @(negedge clk);
    chk("ovr held data", int'(dout[0]), 8'h11);
    chk("ovr held valid", int'(vld[0]), 1);
    chk("ovr sticky", int'(ovr[0]), 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr handshake valid", int'(vld[0]), 0);
    chk("ovr handshake clear", int'(ovr[0]), 0);
    repeat (4) @(negedge clk);
    chk("ovr dropped word", count_obs(0), 0);

    // One-clock glitch on an idle line
    @(negedge clk);
    rx[0] = 1'b0;
    t0 = cyc;
    @(negedge clk);
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch busy", int'(busy[0]), 1);
    repeat (B / 2 + 2) @(negedge clk);
    chk("glitch idle", int'(busy[0]), 0);
    repeat (2 * B) @(negedge clk);
    chk("glitch no word", count_obs(0), 0);
    chk("glitch valid", int'(vld[0]), 0);

    // Reset during data bit 4 of 0x5A, then a clean 0x96
    send(0, 8'h5A, 1'b0, 2'b11, 1'b1, 5, t0);
    chk("midrst busy", int'(busy[0]), 0);
    chk("midrst valid", int'(vld[0]), 0);
    send(0, 8'h96, 1'b0, 2'b11, 1'b1, -1, t0);
    expect_word("after rst", 0, 8'h96, 1'b0, 1'b0, t0);
    chk("after rst extra", count_obs(0), 0);

    // Random frames against the frame-level model
    for (int r = 0; r < 16; r++) begin
      d    = $urandom_range(0, 1);
      data = 8'($urandom);
      flip = (d == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      ok   = ($urandom_range(0, 3) != 0);
      send(d, data, flip, {1'b1, ok}, 1'b1, -1, t0);
      expect_word($sformatf("rand%0d", r), d, data, !ok, flip, t0);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
